// File: rtl/ip_fixer.sv
// Post-encap fix-up: rewrites the outer IPv4 total length from the IOQ byte count
// and recomputes the outer IPv4 header checksum; everything else passes through.
module ip_fixer #(
  parameter int                       DATA_WIDTH         = 64,
  parameter int                       CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0]    IOQ_STAGE_NUM      = 8'hFF,
  parameter int                       PKT_BYTE_CNT_WIDTH = 11,
  parameter int                       IOQ_BYTE_LEN_POS   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy
);

  localparam int WORD_W     = DATA_WIDTH + CTRL_WIDTH;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 4;
  localparam int CNT_W      = 5;
  localparam int N_HOLD     = 5;

  localparam logic [2:0] ST_MOD_HDRS = 3'd0;
  localparam logic [2:0] ST_BUFFER   = 3'd1;
  localparam logic [2:0] ST_CALC     = 3'd2;
  localparam logic [2:0] ST_EMIT     = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;

  // ---------------------------------------------------------------------------
  // Input fallthrough FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  nearly_full_q, nearly_full_d;
  logic                  fifo_empty, fifo_wr, fifo_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign fifo_empty             = (count_q == '0);
  assign {head_ctrl, head_data} = fifo_mem[rd_ptr_q];
  assign fifo_wr                = in_wr && ((count_q != CNT_W'(FIFO_DEPTH)) || fifo_rd);
  assign in_rdy                 = !nearly_full_q;

  always_comb begin
    wr_ptr_d = fifo_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr && !fifo_rd)      count_d = count_q + CNT_W'(1);
    else if (!fifo_wr && fifo_rd) count_d = count_q - CNT_W'(1);
    nearly_full_d = (count_d >= CNT_W'(FIFO_DEPTH - 1));
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= {in_ctrl, in_data};
  end

  // ---------------------------------------------------------------------------
  // Packet FSM and header holding registers
  // ---------------------------------------------------------------------------
  logic [2:0]                    state_q, state_d;
  logic [2:0]                    buf_cnt_q, buf_cnt_d;
  logic [2:0]                    emit_idx_q, emit_idx_d;
  logic [2:0]                    emit_len_q, emit_len_d;
  logic                          have_len_q, have_len_d;
  logic                          fix_q, fix_d;
  logic [PKT_BYTE_CNT_WIDTH-1:0] byte_len_q, byte_len_d;
  logic [WORD_W-1:0]             hold_q [N_HOLD];
  logic [WORD_W-1:0]             hold_d [N_HOLD];

  logic [15:0] new_len, csum;
  logic [19:0] sum_raw, sum_fold1;
  logic        fix_ok;
  logic [WORD_W-1:0] emit_word;

  // Checksum over the outer IPv4 header with the new length, old checksum excluded.
  always_comb begin
    new_len = 16'(byte_len_q) - 16'd14;
    sum_raw = 20'(hold_q[1][15:0])  + 20'(new_len)
            + 20'(hold_q[2][47:32]) + 20'(hold_q[2][31:16]) + 20'(hold_q[2][15:0])
            + 20'(hold_q[3][47:32]) + 20'(hold_q[3][31:16]) + 20'(hold_q[3][15:0])
            + 20'(hold_q[4][63:48]);
    sum_fold1 = {4'b0, sum_raw[15:0]} + {16'b0, sum_raw[19:16]};
    csum      = ~(sum_fold1[15:0] + {12'b0, sum_fold1[19:16]});
    fix_ok    = have_len_q
             && (hold_q[1][31:16] == 16'h0800)
             && (hold_q[1][15:8]  == 8'h45)
             && (byte_len_q >= PKT_BYTE_CNT_WIDTH'(34));
  end

  always_comb begin
    emit_word = hold_q[emit_idx_q];
    if (fix_q && emit_idx_q == 3'd2) emit_word[63:48] = new_len;
    if (fix_q && emit_idx_q == 3'd3) emit_word[63:48] = csum;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    buf_cnt_d  = buf_cnt_q;
    emit_idx_d = emit_idx_q;
    emit_len_d = emit_len_q;
    have_len_d = have_len_q;
    fix_d      = fix_q;
    byte_len_d = byte_len_q;
    hold_d     = hold_q;
    fifo_rd    = 1'b0;
    out_wr     = 1'b0;
    out_data   = '0;
    out_ctrl   = '0;

    case (state_q)
      ST_MOD_HDRS: begin
        if (!fifo_empty) begin
          if (head_ctrl != '0) begin
            out_data = head_data;
            out_ctrl = head_ctrl;
            out_wr   = out_rdy;
            fifo_rd  = out_rdy;
            if (out_rdy && head_ctrl == IOQ_STAGE_NUM) begin
              byte_len_d = head_data[IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH];
              have_len_d = 1'b1;
            end
          end else begin
            // First data word stays at the FIFO head for BUFFER to pop.
            state_d   = ST_BUFFER;
            buf_cnt_d = 3'd0;
          end
        end
      end

      ST_BUFFER: begin
        if (!fifo_empty) begin
          fifo_rd           = 1'b1;
          hold_d[buf_cnt_q] = {head_ctrl, head_data};
          buf_cnt_d         = buf_cnt_q + 3'd1;
          if (buf_cnt_q == 3'd4) begin
            state_d = ST_CALC;
          end else if (head_ctrl != '0) begin
            fix_d      = 1'b0;
            emit_len_d = buf_cnt_q + 3'd1;
            emit_idx_d = 3'd0;
            state_d    = ST_EMIT;
          end
        end
      end

      ST_CALC: begin
        fix_d      = fix_ok;
        emit_len_d = 3'd5;
        emit_idx_d = 3'd0;
        state_d    = ST_EMIT;
      end

      ST_EMIT: begin
        {out_ctrl, out_data} = emit_word;
        out_wr               = out_rdy;
        if (out_rdy) begin
          if (emit_idx_q == emit_len_q - 3'd1) begin
            if (emit_word[WORD_W-1:DATA_WIDTH] != '0) begin
              state_d    = ST_MOD_HDRS;
              have_len_d = 1'b0;
              fix_d      = 1'b0;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            emit_idx_d = emit_idx_q + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!fifo_empty) begin
          out_data = head_data;
          out_ctrl = head_ctrl;
          out_wr   = out_rdy;
          fifo_rd  = out_rdy;
          if (out_rdy && head_ctrl != '0) begin
            state_d    = ST_MOD_HDRS;
            have_len_d = 1'b0;
            fix_d      = 1'b0;
          end
        end
      end

      default: state_d = ST_MOD_HDRS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      nearly_full_q <= 1'b1;
      state_q       <= ST_MOD_HDRS;
      buf_cnt_q     <= '0;
      emit_idx_q    <= '0;
      emit_len_q    <= '0;
      have_len_q    <= 1'b0;
      fix_q         <= 1'b0;
      byte_len_q    <= '0;
      for (int i = 0; i < N_HOLD; i++) hold_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      nearly_full_q <= nearly_full_d;
      state_q       <= state_d;
      buf_cnt_q     <= buf_cnt_d;
      emit_idx_q    <= emit_idx_d;
      emit_len_q    <= emit_len_d;
      have_len_q    <= have_len_d;
      fix_q         <= fix_d;
      byte_len_q    <= byte_len_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: tb/tb_ip_fixer.sv
// Directed bench for ip_fixer: table of packet records with hand-computed
// length/checksum, plus backpressure and mid-packet reset sequences.
module tb_ip_fixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;

  always #5 clk = ~clk;

  ip_fixer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_wr    (in_wr),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy)
  );

  typedef struct {
    bit          has_ioq;
    logic [10:0] byte_len;
    logic [15:0] ethertype;
    logic [7:0]  verihl;
    logic [15:0] ttl_proto;
    int          n_data;
    logic [7:0]  eop_ctrl;
    bit          exp_fix;
    logic [15:0] exp_len;
    logic [15:0] exp_csum;
  } vec_t;

  localparam int N_VECS = 11;
  vec_t vecs [N_VECS];

  logic [71:0] in_words  [$];
  logic [71:0] exp_words [$];
  logic [71:0] got_q     [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output collector; also flags any write offered while downstream is stalled.
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_rdy) check("no_wr_while_stalled", {71'b0, out_wr}, 72'b0);
      if (out_wr) got_q.push_back({out_ctrl, out_data});
    end
  end

  task automatic build(input vec_t v);
    logic [63:0] w;
    logic [7:0]  c;
    in_words.push_back({8'h20, 64'h0123_4567_89AB_CDEF});
    exp_words.push_back({8'h20, 64'h0123_4567_89AB_CDEF});
    if (v.has_ioq) begin
      w = {16'h0004, 37'h0, v.byte_len};
      in_words.push_back({8'hFF, w});
      exp_words.push_back({8'hFF, w});
    end
    for (int i = 0; i < v.n_data; i++) begin
      case (i)
        0:       w = 64'h0011_2233_4455_6677;
        1:       w = {32'h8899_AABB, v.ethertype, v.verihl, 8'h00};
        2:       w = {32'h0000_0000, 16'h4000, v.ttl_proto};
        3:       w = {16'hFFFF, 32'h0A00_0001, 16'h0A00};
        4:       w = {16'h0002, 48'hDEAD_BEEF_0000};
        default: w = {32'hCAFE_0000, 32'(i)};
      endcase
      c = (i == v.n_data - 1) ? v.eop_ctrl : 8'h00;
      in_words.push_back({c, w});
      if (v.exp_fix && i == 2) w[63:48] = v.exp_len;
      if (v.exp_fix && i == 3) w[63:48] = v.exp_csum;
      exp_words.push_back({c, w});
    end
  endtask

  task automatic push(input logic [71:0] w);
    int guard = 0;
    while (!in_rdy && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) check("in_rdy_timeout", {71'b0, in_rdy}, 72'd1);
    {in_ctrl, in_data} = w;
    in_wr = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n && in_words.size() > 0; i++) push(in_words.pop_front());
  endtask

  task automatic wait_out(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_pkts(input string name);
    check({name, "_count"}, 72'(got_q.size()), 72'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_q.size(); i++)
      check(name, got_q[i], exp_words[i]);
    got_q.delete();
    exp_words.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit stop;
    int total;

    //           ioq   len      etype     vihl   ttl_proto  n  eop    fix  len       csum
    vecs[0]  = '{1'b1, 11'd102, 16'h0800, 8'h45, 16'h4004,  8, 8'h08, 1'b1, 16'h0058, 16'h26A0};
    vecs[1]  = '{1'b1, 11'd60,  16'h0800, 8'h45, 16'h4004,  6, 8'h01, 1'b1, 16'h002E, 16'h26CA};
    vecs[2]  = '{1'b1, 11'd34,  16'h0800, 8'h45, 16'h4004,  5, 8'h80, 1'b1, 16'h0014, 16'h26E4};
    vecs[3]  = '{1'b1, 11'd33,  16'h0800, 8'h45, 16'h4004,  7, 8'h02, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 11'd102, 16'h0806, 8'h45, 16'h4004,  8, 8'h08, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, 11'd102, 16'h0800, 8'h46, 16'h4004,  8, 8'h08, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 11'd102, 16'h0800, 8'h45, 16'h4004,  8, 8'h08, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 11'd102, 16'h0800, 8'h45, 16'h4004,  4, 8'h40, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 11'd2047,16'h0800, 8'h45, 16'h4004,  9, 8'h10, 1'b1, 16'h07F1, 16'h1F07};
    vecs[9]  = '{1'b1, 11'd102, 16'h0800, 8'h45, 16'hFFFF,  6, 8'h04, 1'b1, 16'h0058, 16'h66A4};
    vecs[10] = '{1'b1, 11'd102, 16'h0800, 8'h45, 16'h4004,  2, 8'h04, 1'b0, 16'h0000, 16'h0000};

    reset   = 1'b1;
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_wr",   {71'b0, out_wr}, 72'b0);
    check("reset_out_data", {8'b0, out_data}, 72'b0);
    check("reset_out_ctrl", {64'b0, out_ctrl}, 72'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_rdy_after_reset", {71'b0, in_rdy}, 72'd1);

    // Table: one packet at a time, downstream always ready.
    for (int v = 0; v < N_VECS; v++) begin
      build(vecs[v]);
      total = exp_words.size();
      send_n(in_words.size());
      wait_out(total);
      compare_pkts($sformatf("vec%0d", v));
    end

    // 20 back-to-back packets with random 50% downstream readiness.
    for (int p = 0; p < 20; p++) build(vecs[p % N_VECS]);
    total = exp_words.size();
    stop  = 1'b0;
    fork
      begin
        send_n(in_words.size());
        wait_out(total);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    out_rdy = 1'b1;
    compare_pkts("backpressure");

    // Back-to-back fixed packets, then reset while packet 2 is in PAYLOAD.
    build(vecs[0]);
    vecs[0].n_data = 12;
    build(vecs[0]);
    vecs[0].n_data = 8;
    send_n(18);
    wait_out(18);
    while (exp_words.size() > 18) void'(exp_words.pop_back());
    compare_pkts("b2b_pkt1");
    out_rdy = 1'b0;
    send_n(2);
    in_words.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    #2;
    check("out_wr_after_reset", {71'b0, out_wr}, 72'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    @(posedge clk); #1;
    check("in_rdy_after_midpkt_reset", {71'b0, in_rdy}, 72'd1);
    check("no_stale_word_after_reset", {71'b0, out_wr}, 72'b0);
    build(vecs[8]);
    total = exp_words.size();
    send_n(in_words.size());
    wait_out(total);
    compare_pkts("pkt3_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
